// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo-N counter family.
// Holds the direction/mode encodings and a width helper usable in parameter defaults.
package counter_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
  typedef enum logic {MODE_SAT = 1'b0, MODE_WRAP = 1'b1} wrap_mode_e;

  // Never returns 0, so a MOD=1 misconfiguration still elaborates far enough to be reported.
  function automatic int cnt_width(input int mod);
    return (mod <= 2) ? 1 : $clog2(mod);
  endfunction

endpackage

// File: rtl/mod_n_next.sv
// Combinational next-count step for a modulo-N counter: computes the stepped value,
// whether the count sits at its terminal value, and whether this step would wrap.
module mod_n_next
  import counter_pkg::*;
#(
  parameter int MOD   = 5,
  parameter int WIDTH = cnt_width(MOD)
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] nxt,
  output logic             at_term,
  output logic             wraps
);

  localparam logic [WIDTH:0]   MOD_L = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0]   ONE_L = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] TOP_L = WIDTH'(MOD - 1);

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] step;

  // The extra bit keeps q+1 from silently overflowing, so the range check against MOD is exact.
  always_comb begin
    // NOTE: every output gets a default before any branch; a path that skips an assignment would infer a latch.
    q_ext   = {1'b0, q};
    step    = '0;
    nxt     = q;
    at_term = 1'b0;
    wraps   = 1'b0;
    if (dir_e'(dir) == DIR_UP) begin
      step    = q_ext + ONE_L;
      at_term = (step >= MOD_L);
      if (!at_term) begin
        nxt = step[WIDTH-1:0];
      end else if (wrap_mode_e'(wrap_en) == MODE_WRAP) begin
        nxt   = '0;
        wraps = 1'b1;
      end
    end else begin
      at_term = (q_ext == '0);
      if (!at_term) begin
        step = q_ext - ONE_L;
        nxt  = step[WIDTH-1:0];
      end else if (wrap_mode_e'(wrap_en) == MODE_WRAP) begin
        nxt   = TOP_L;
        wraps = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_n_counter.sv
// Parametrised modulo-N up/down counter with wrap/saturate, synchronous clear and load,
// registered wrap/load-error pulses and a combinational terminal count for cascading.
module mod_n_counter
  import counter_pkg::*;
#(
  parameter int MOD   = 5,
  parameter int WIDTH = cnt_width(MOD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             t,
  input  logic             dir,
  input  logic             wrap_en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrapped,
  output logic             load_err
);

  if (MOD < 2) begin : g_bad_mod
    $error("mod_n_counter: MOD must be at least 2");
  end
  if ((2 ** WIDTH) < MOD) begin : g_bad_width
    $error("mod_n_counter: WIDTH too narrow for MOD");
  end

  localparam logic [WIDTH:0] MOD_L = (WIDTH+1)'(MOD);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrapped_q, wrapped_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] nxt;
  logic             at_term;
  logic             wraps;

  mod_n_next #(.MOD(MOD), .WIDTH(WIDTH)) u_next (
    .q       (q_q),
    .dir     (dir),
    .wrap_en (wrap_en),
    .nxt     (nxt),
    .at_term (at_term),
    .wraps   (wraps)
  );

  // Pulses default low so they last exactly one cycle; clr beats load beats t.
  always_comb begin
    q_d        = q_q;
    wrapped_d  = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      if ({1'b0, load_val} < MOD_L) begin
        q_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (t) begin
      q_d       = nxt;
      wrapped_d = wraps;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q        <= '0;
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrapped_q  <= wrapped_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = q_q;
  assign wrapped  = wrapped_q;
  assign load_err = load_err_q;
  assign tc       = t & at_term;

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter: MOD=5 behaviour plus MOD=8 and MOD=10 sweeps.
module tb_mod_n_counter;

  logic       clk = 1'b0;
  logic       rst_n, t, dir, wrap_en, clr, load;
  logic [2:0] lv5, lv8;
  logic [3:0] lv10;
  logic [2:0] q5, q8;
  logic [3:0] q10;
  logic       tc5, tc8, tc10;
  logic       wr5, wr8, wr10;
  logic       le5, le8, le10;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mod_n_counter #(.MOD(5)) u_m5 (
    .clk(clk), .rst_n(rst_n), .t(t), .dir(dir), .wrap_en(wrap_en), .clr(clr),
    .load(load), .load_val(lv5), .q(q5), .tc(tc5), .wrapped(wr5), .load_err(le5)
  );
  mod_n_counter #(.MOD(8)) u_m8 (
    .clk(clk), .rst_n(rst_n), .t(t), .dir(dir), .wrap_en(wrap_en), .clr(clr),
    .load(load), .load_val(lv8), .q(q8), .tc(tc8), .wrapped(wr8), .load_err(le8)
  );
  mod_n_counter #(.MOD(10)) u_m10 (
    .clk(clk), .rst_n(rst_n), .t(t), .dir(dir), .wrap_en(wrap_en), .clr(clr),
    .load(load), .load_val(lv10), .q(q10), .tc(tc10), .wrapped(wr10), .load_err(le10)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; t = 1'b0; dir = 1'b1; wrap_en = 1'b1; clr = 1'b0; load = 1'b0;
    lv5 = '0; lv8 = '0; lv10 = '0;
    #3;
    total_cnt++;
    if (q5 !== 3'd0 || wr5 !== 1'b0 || le5 !== 1'b0)
      $display("FAIL reset_state q=%0d wrapped=%b load_err=%b want 0/0/0", q5, wr5, le5);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (q5 !== 3'd0 || tc5 !== 1'b0)
      $display("FAIL reset_idle q=%0d tc=%b want 0/0", q5, tc5);
    else pass_cnt++;
  endtask

  task automatic test_up_wrap();
    int exp_q[6]  = '{1, 2, 3, 4, 0, 1};
    int exp_wr[6] = '{0, 0, 0, 0, 1, 0};
    int exp_tc[6] = '{0, 0, 0, 1, 0, 0};
    t = 1'b1; dir = 1'b1; wrap_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total_cnt++;
      if (q5 !== 3'(exp_q[i]) || wr5 !== 1'(exp_wr[i]) || tc5 !== 1'(exp_tc[i]))
        $display("FAIL up_wrap[%0d] q=%0d wr=%b tc=%b want %0d/%0d/%0d",
                 i, q5, wr5, tc5, exp_q[i], exp_wr[i], exp_tc[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_down_wrap();
    int exp_q[6]  = '{4, 3, 2, 1, 0, 4};
    int exp_wr[6] = '{1, 0, 0, 0, 0, 1};
    int exp_tc[6] = '{0, 0, 0, 0, 1, 0};
    clr = 1'b1;
    step();
    clr = 1'b0;
    total_cnt++;
    if (q5 !== 3'd0) $display("FAIL down_clr q=%0d want 0", q5);
    else pass_cnt++;
    dir = 1'b0; wrap_en = 1'b1; t = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total_cnt++;
      if (q5 !== 3'(exp_q[i]) || wr5 !== 1'(exp_wr[i]) || tc5 !== 1'(exp_tc[i]))
        $display("FAIL down_wrap[%0d] q=%0d wr=%b tc=%b want %0d/%0d/%0d",
                 i, q5, wr5, tc5, exp_q[i], exp_wr[i], exp_tc[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturate();
    int exp_q[5]  = '{3, 2, 1, 0, 0};
    int exp_tc[5] = '{0, 0, 0, 1, 1};
    t = 1'b0; load = 1'b1; lv5 = 3'd3;
    step();
    load = 1'b0;
    total_cnt++;
    if (q5 !== 3'd3 || le5 !== 1'b0) $display("FAIL sat_load q=%0d le=%b want 3/0", q5, le5);
    else pass_cnt++;
    t = 1'b1; dir = 1'b1; wrap_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (q5 !== 3'd4 || wr5 !== 1'b0 || tc5 !== 1'b1)
        $display("FAIL sat_up[%0d] q=%0d wr=%b tc=%b want 4/0/1", i, q5, wr5, tc5);
      else pass_cnt++;
    end
    dir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if (q5 !== 3'(exp_q[i]) || wr5 !== 1'b0 || tc5 !== 1'(exp_tc[i]))
        $display("FAIL sat_down[%0d] q=%0d wr=%b tc=%b want %0d/0/%0d",
                 i, q5, wr5, tc5, exp_q[i], exp_tc[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_load_clr();
    t = 1'b0; load = 1'b1; lv5 = 3'd2;
    step();
    total_cnt++;
    if (q5 !== 3'd2 || le5 !== 1'b0) $display("FAIL load_ok q=%0d le=%b want 2/0", q5, le5);
    else pass_cnt++;
    lv5 = 3'd6;
    step();
    total_cnt++;
    if (q5 !== 3'd2 || le5 !== 1'b1) $display("FAIL load_bad q=%0d le=%b want 2/1", q5, le5);
    else pass_cnt++;
    load = 1'b0;
    step();
    total_cnt++;
    if (q5 !== 3'd2 || le5 !== 1'b0) $display("FAIL load_err_pulse q=%0d le=%b want 2/0", q5, le5);
    else pass_cnt++;
    // load wins over t
    load = 1'b1; lv5 = 3'd3; t = 1'b1; dir = 1'b1; wrap_en = 1'b1;
    step();
    total_cnt++;
    if (q5 !== 3'd3) $display("FAIL load_over_t q=%0d want 3", q5);
    else pass_cnt++;
    lv5 = 3'd7;
    step();
    total_cnt++;
    if (q5 !== 3'd3 || le5 !== 1'b1) $display("FAIL load_bad_t q=%0d le=%b want 3/1", q5, le5);
    else pass_cnt++;
    clr = 1'b1; lv5 = 3'd1;
    step();
    clr = 1'b0; load = 1'b0; t = 1'b0;
    total_cnt++;
    if (q5 !== 3'd0 || le5 !== 1'b0 || wr5 !== 1'b0)
      $display("FAIL clr_priority q=%0d le=%b wr=%b want 0/0/0", q5, le5, wr5);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    t = 1'b1; dir = 1'b1; wrap_en = 1'b1;
    step();
    step();
    total_cnt++;
    if (q5 !== 3'd2) $display("FAIL async_pre q=%0d want 2", q5);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (q5 !== 3'd0 || wr5 !== 1'b0) $display("FAIL async_now q=%0d wr=%b want 0/0", q5, wr5);
    else pass_cnt++;
    step();
    total_cnt++;
    if (q5 !== 3'd0) $display("FAIL async_hold q=%0d want 0", q5);
    else pass_cnt++;
    #2 rst_n = 1'b1;
    step();
    total_cnt++;
    if (q5 !== 3'd1) $display("FAIL async_resume1 q=%0d want 1", q5);
    else pass_cnt++;
    step();
    total_cnt++;
    if (q5 !== 3'd2) $display("FAIL async_resume2 q=%0d want 2", q5);
    else pass_cnt++;
  endtask

  task automatic test_wide_sweeps();
    int e8, e10;
    logic w8, w10, etc10;
    t = 1'b0; clr = 1'b0; load = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    e8 = 0; e10 = 0;
    t = 1'b1; dir = 1'b1; wrap_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 12) dir = 1'b0;
      #1;
      etc10 = dir ? (e10 == 9) : (e10 == 0);
      total_cnt++;
      if (tc10 !== etc10) $display("FAIL sweep_tc10[%0d] tc=%b want %b", i, tc10, etc10);
      else pass_cnt++;
      if (dir) begin
        w8 = (e8 == 7); w10 = (e10 == 9);
        e8 = (e8 + 1) % 8; e10 = (e10 + 1) % 10;
      end else begin
        w8 = (e8 == 0); w10 = (e10 == 0);
        e8 = (e8 + 7) % 8; e10 = (e10 + 9) % 10;
      end
      step();
      total_cnt++;
      if (q8 !== 3'(e8) || wr8 !== w8 || q10 !== 4'(e10) || wr10 !== w10 || q10 > 4'd9)
        $display("FAIL sweep[%0d] q8=%0d wr8=%b q10=%0d wr10=%b want %0d/%b/%0d/%b",
                 i, q8, wr8, q10, wr10, e8, w8, e10, w10);
      else pass_cnt++;
    end
    t = 1'b0; load = 1'b1; lv8 = 3'd7; lv10 = 4'd9;
    step();
    load = 1'b0; t = 1'b1; dir = 1'b1; wrap_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++;
      if (q8 !== 3'd7 || q10 !== 4'd9 || wr8 !== 1'b0 || wr10 !== 1'b0)
        $display("FAIL wide_sat[%0d] q8=%0d q10=%0d wr=%b%b want 7/9/00", i, q8, q10, wr8, wr10);
      else pass_cnt++;
    end
    load = 1'b1; lv8 = 3'd3; lv10 = 4'd15;
    step();
    total_cnt++;
    if (q10 !== 4'd9 || le10 !== 1'b1 || q8 !== 3'd3 || le8 !== 1'b0)
      $display("FAIL wide_load q10=%0d le10=%b q8=%0d le8=%b want 9/1/3/0", q10, le10, q8, le8);
    else pass_cnt++;
    load = 1'b0; wrap_en = 1'b1;
    step();
    total_cnt++;
    if (q10 !== 4'd0 || wr10 !== 1'b1 || le10 !== 1'b0 || q8 !== 3'd4)
      $display("FAIL wide_wrap q10=%0d wr10=%b le10=%b q8=%0d want 0/1/0/4", q10, wr10, le10, q8);
    else pass_cnt++;
    t = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_load_clr();
    test_async_reset();
    test_wide_sweeps();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
